// File: rtl/ghrd_reset_sequencer.sv
// Board reset sequencer: debounces the push-button and releases the DDR3 PLL,
// system and Ethernet PHY resets in order, gated on DDR3 PHY ready with timeout retry.
module ghrd_reset_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 65536,
  parameter int unsigned PLL_HOLD        = 256,
  parameter int unsigned READY_TIMEOUT   = 1048576,
  parameter int unsigned SYS_HOLD        = 1024,
  parameter int unsigned PHY_HOLD        = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ext_resetn,
  input  logic       mem_phy_resetn,
  output logic       pll_resetn,
  output logic       sys_resetn,
  output logic       enet_resetn,
  output logic       timeout,
  output logic [7:0] retry_count,
  output logic [2:0] state
);

  localparam int unsigned MAX_A = (DEBOUNCE_CYCLES > PLL_HOLD) ? DEBOUNCE_CYCLES : PLL_HOLD;
  localparam int unsigned MAX_B = (READY_TIMEOUT > SYS_HOLD) ? READY_TIMEOUT : SYS_HOLD;
  localparam int unsigned MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned MAX_P = (MAX_C > PHY_HOLD) ? MAX_C : PHY_HOLD;
  localparam int CW = $clog2(MAX_P) + 1;

  typedef enum logic [2:0] {
    S_PLL_RST  = 3'd0,
    S_PLL_WAIT = 3'd1,
    S_SYS_HOLD = 3'd2,
    S_PHY_HOLD = 3'd3,
    S_RUN      = 3'd4
  } state_t;

  state_t          cur_state;
  state_t          nxt_state;
  logic [1:0]      btn_sync;
  logic [1:0]      rdy_sync;
  logic            btn_s;
  logic            rdy_s;
  logic [CW-1:0]   press_cnt;
  logic            btn_press;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;
  logic            hit_timeout;

  // Button synchronizer idles released, ready synchronizer idles not-ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_sync <= 2'b11;
      rdy_sync <= 2'b00;
    end else begin
      btn_sync <= {btn_sync[0], ext_resetn};
      rdy_sync <= {rdy_sync[0], mem_phy_resetn};
    end
  end

  assign btn_s = btn_sync[1];
  assign rdy_s = rdy_sync[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      press_cnt <= '0;
      btn_press <= 1'b0;
    end else if (btn_s) begin
      press_cnt <= '0;
      btn_press <= 1'b0;
    end else if (press_cnt != CW'(DEBOUNCE_CYCLES)) begin
      press_cnt <= press_cnt + CW'(1);
      btn_press <= (press_cnt == CW'(DEBOUNCE_CYCLES - 1));
    end
  end

  // Priority: button press, then ready loss, then timeout, then hold expiry.
  always_comb begin
    nxt_state   = cur_state;
    cnt_nxt     = cnt + CW'(1);
    hit_timeout = 1'b0;
    case (cur_state)
      S_PLL_RST: begin
        if (cnt == CW'(PLL_HOLD - 1)) nxt_state = S_PLL_WAIT;
      end
      S_PLL_WAIT: begin
        if (rdy_s) begin
          nxt_state = S_SYS_HOLD;
        end else if (cnt == CW'(READY_TIMEOUT - 1)) begin
          nxt_state   = S_PLL_RST;
          hit_timeout = 1'b1;
        end
      end
      S_SYS_HOLD: begin
        if (!rdy_s) nxt_state = S_PLL_RST;
        else if (cnt == CW'(SYS_HOLD - 1)) nxt_state = S_PHY_HOLD;
      end
      S_PHY_HOLD: begin
        if (!rdy_s) nxt_state = S_PLL_RST;
        else if (cnt == CW'(PHY_HOLD - 1)) nxt_state = S_RUN;
      end
      S_RUN: begin
        cnt_nxt = cnt;
        if (!rdy_s) nxt_state = S_PLL_RST;
      end
      default: nxt_state = S_PLL_RST;
    endcase
    if (btn_press) nxt_state = S_PLL_RST;
    if ((nxt_state != cur_state) || btn_press) cnt_nxt = '0;
  end

  // Outputs decode the next state so they switch on the same edge as the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state   <= S_PLL_RST;
      cnt         <= '0;
      pll_resetn  <= 1'b0;
      sys_resetn  <= 1'b0;
      enet_resetn <= 1'b0;
      timeout     <= 1'b0;
      retry_count <= 8'd0;
    end else begin
      cur_state   <= nxt_state;
      cnt         <= cnt_nxt;
      pll_resetn  <= (nxt_state != S_PLL_RST);
      sys_resetn  <= (nxt_state == S_PHY_HOLD) || (nxt_state == S_RUN);
      enet_resetn <= (nxt_state == S_RUN);
      if (hit_timeout) begin
        timeout <= 1'b1;
        if (retry_count != 8'hFF) retry_count <= retry_count + 8'd1;
      end
    end
  end

  assign state = cur_state;

endmodule

// File: doc/ghrd_reset_sequencer.md
# ghrd_reset_sequencer

Board-level reset sequencer that sits directly upstream of the GHRD top-level SOPC system. It debounces the push-button reset and releases three reset domains in a fixed order: DDR3 PLL, then system, then Ethernet PHY. It gates each release on the DDR3 PHY reporting ready, and it retries with a sticky timeout flag if the PHY never comes up. Outputs drive `global_reset_n_to_the_ddr3_top`, the SOPC `reset_n` and `enet_resetn`.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 65536: number of consecutive synchronized-pressed cycles before a button press is accepted.
- `PLL_HOLD`, 256: cycles the PLL reset is held low.
- `READY_TIMEOUT`, 1048576: cycles to wait for PHY ready before retrying.
- `SYS_HOLD`, 1024: cycles between PHY ready and system reset release.
- `PHY_HOLD`, 4096: cycles between system release and Ethernet release.
- All parameters ≥1. The single internal counter width is clog2(max parameter)+1.

Ports:
- `clk`, in, 1: 50 MHz board clock; the only clock.
- `reset`, in, 1: asynchronous, active-high power-on reset.
- `ext_resetn`, in, 1: raw push-button, active-low, asynchronous to `clk`, bouncy.
- `mem_phy_resetn`, in, 1: DDR3 `reset_phy_clk_n`, asynchronous to `clk`; 1 = PHY out of reset.
- `pll_resetn`, out, 1: to DDR3 `global_reset_n`.
- `sys_resetn`, out, 1: to SOPC `reset_n`.
- `enet_resetn`, out, 1: to Ethernet PHY reset pin.
- `timeout`, out, 1: sticky; 1 = a PHY-ready timeout has occurred.
- `retry_count`, out, 8: number of timeout retries, saturating at 255.
- `state`, out, 3: current FSM state, for debug.

## Operation
- `ext_resetn` and `mem_phy_resetn` each pass through a 2-flop synchronizer. Synchronizer flops reset to 0 for ready and to 1 for the button (released).
- Debounce:
  - `press_cnt` counts consecutive cycles with the synchronized button low.
  - Internal `btn_press` goes to 1 when `press_cnt` reaches `DEBOUNCE_CYCLES`.
  - A synchronized high clears `press_cnt` and `btn_press` on the next edge.
- FSM states and encodings: PLL_RST=0, PLL_WAIT=1, SYS_HOLD=2, PHY_HOLD=3, RUN=4.
- Hold counter: `cnt` clears on every state entry. "Hold N" means the transition occurs on the N-th edge spent in the state.
- State transitions:
  - PLL_RST: hold `PLL_HOLD` → PLL_WAIT. While `btn_press`=1, stay and keep `cnt` cleared.
  - PLL_WAIT: if synchronized ready = 1 → SYS_HOLD on the next edge. Else, on the `READY_TIMEOUT`-th edge → PLL_RST, set `timeout`=1, increment `retry_count` (saturating).
  - SYS_HOLD: hold `SYS_HOLD` → PHY_HOLD.
  - PHY_HOLD: hold `PHY_HOLD` → RUN.
  - RUN: stays in RUN.
- Global aborts:
  - From any state, `btn_press`=1 → PLL_RST.
  - From SYS_HOLD, PHY_HOLD or RUN, synchronized ready = 0 → PLL_RST.
- Outputs are registered and decoded from the next state, so they change on the same edge as `state`:
  - `pll_resetn` = 1 in states 1–4.
  - `sys_resetn` = 1 in states 3–4.
  - `enet_resetn` = 1 in state 4.
- `timeout` and `retry_count` clear only on `reset`. A successful sequence does not clear them.

## Timing
- Reset values while `reset`=1: `state`=0, `pll_resetn`=`sys_resetn`=`enet_resetn`=0, `timeout`=0, `retry_count`=0, all counters 0.
- Edge 1 is the first rising edge after `reset` falls.
- If `mem_phy_resetn` is steady high and the button is released:
  - `pll_resetn` rises at edge `PLL_HOLD`.
  - `sys_resetn` rises at edge `PLL_HOLD`+1+`SYS_HOLD`.
  - `enet_resetn` rises `PHY_HOLD` edges after `sys_resetn`.
- An accepted button press drops all three outputs on the edge after `btn_press` sets. Total latency from the raw press is 2 + `DEBOUNCE_CYCLES` + 1 edges.
- Priority of simultaneous events, highest first:
  - `btn_press`;
  - ready loss;
  - timeout;
  - hold expiry.
- Button press and timeout on the same edge: go to PLL_RST, and `timeout`/`retry_count` still update.
- Ready loss on the same edge as hold expiry: ready loss wins and the FSM goes to PLL_RST.
- `reset` asserted mid-sequence forces all outputs to 0 immediately, without waiting for `clk`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `PLL_HOLD`=4, `READY_TIMEOUT`=32, `SYS_HOLD`=8, `PHY_HOLD`=16.
- Clean bring-up: ready high, button released, release `reset` → `pll_resetn` rises at edge 4, `sys_resetn` at edge 13, `enet_resetn` at edge 29; `state` ends at 4.
- Timeout retry: ready held low → `timeout`=1 and `retry_count`=1 at edge 36, `pll_resetn`=0 at that edge. Raise ready afterwards → sequence completes and `timeout` stays 1.
- Debounce: from RUN, a 3-cycle button low pulse → no output change. A 6-cycle low pulse → all three outputs 0 at edge 7 after the press starts, then the full sequence reruns after release.
- Ready loss: drop `mem_phy_resetn` in RUN → all outputs 0 three edges later; `state`=0.
- Saturation: ready low for 300 timeouts → `retry_count`=255 with no wrap.
- Async reset: assert `reset` between edges in PHY_HOLD → outputs 0 before the next `clk` edge.
